// File: rtl/parallel_adder.sv
// WIDTH-bit ripple-carry adder built from full-adder cells, with sum, carry-out,
// signed overflow and zero flags captured in a one-cycle output register stage.

module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

module parallel_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero,
  output logic             out_valid
);

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  assign carry_s[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_fa (
      .a_i (A[i]),
      .b_i (B[i]),
      .c_i (carry_s[i]),
      .s_o (sum_s[i]),
      .c_o (carry_s[i+1])
    );
  end

  // Registers only load when in_valid is high, so idle-cycle operands never reach the outputs.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d  = sum_s;
      cout_d = carry_s[WIDTH];
      ovf_d  = carry_s[WIDTH] ^ carry_s[WIDTH-1];
      zero_d = (sum_s == {WIDTH{1'b0}});
    end else begin
      sum_d  = sum_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Overflow  = ovf_q;
  assign Zero      = zero_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_parallel_adder.sv
// Directed and exhaustive self-checking bench for the 4-bit parallel_adder.

module tb_parallel_adder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a_s;
  logic [3:0] b_s;
  logic       cin_s;
  logic [3:0] sum_s;
  logic       cout_s;
  logic       ovf_s;
  logic       zero_s;
  logic       out_valid_s;

  int n_cmp;
  int n_err;

  parallel_adder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (a_s),
    .B         (b_s),
    .Cin       (cin_s),
    .Sum       (sum_s),
    .Cout      (cout_s),
    .Overflow  (ovf_s),
    .Zero      (zero_s),
    .out_valid (out_valid_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference from integer addition; overflow from the operand/result sign rule.
  function automatic logic [6:0] golden(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] t;
    logic       ov;
    t  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    ov = (a[3] == b[3]) && (t[3] != a[3]);
    return {(t[3:0] == 4'b0000), ov, t[4], t[3:0]};
  endfunction

  task automatic check_all(input string tag, input logic [3:0] sum, input logic cout,
                           input logic ov, input logic zero, input logic vld);
    check({tag, ".sum"},  64'(sum_s),       64'(sum));
    check({tag, ".cout"}, 64'(cout_s),      64'(cout));
    check({tag, ".ovf"},  64'(ovf_s),       64'(ov));
    check({tag, ".zero"}, 64'(zero_s),      64'(zero));
    check({tag, ".vld"},  64'(out_valid_s), 64'(vld));
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic cin);
    in_valid = v;
    a_s      = a;
    b_s      = b;
    cin_s    = cin;
  endtask

  logic [6:0] exp_r;
  logic       pend;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 1'b0);

    // Reset held with toggling inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 4'(i * 5 + 3), 4'(15 - i), 1'(i));
    end
    @(negedge clk);
    check_all("reset", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;

    drive(1'b1, 4'b0011, 4'b0101, 1'b0);
    @(negedge clk);
    check_all("t2", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 4'b1111, 4'b0001, 1'b0);
    @(negedge clk);
    check_all("t3", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 4'b1001, 4'b0110, 1'b1);
    @(negedge clk);
    check_all("t4", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 4'b0110, 4'b0111, 1'b1);
    @(negedge clk);
    check_all("t5", 4'b1110, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 4'b1111, 4'b1111, 1'b1);
    @(negedge clk);
    check_all("t5_hold1", 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
    @(negedge clk);
    check_all("t5_hold2", 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0);

    // Exhaustive back-to-back sweep with an asynchronous reset partway through
    pend = 1'b0;
    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      if (pend) begin
        check_all($sformatf("ex%0d", k - 1), exp_r[3:0], exp_r[4], exp_r[5], exp_r[6], 1'b1);
      end
      if (k == 200) begin
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_all("rst_held", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
      end
      drive(1'b1, 4'(k >> 5), 4'(k >> 1), 1'(k));
      exp_r = golden(4'(k >> 5), 4'(k >> 1), 1'(k));
      pend  = 1'b1;
    end
    @(negedge clk);
    check_all("ex511", exp_r[3:0], exp_r[4], exp_r[5], exp_r[6], 1'b1);
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    check_all("final_idle", exp_r[3:0], exp_r[4], exp_r[5], exp_r[6], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/parallel_adder.md
Name: parallel_adder

Overview:
WIDTH-bit parallel (ripple-carry) adder with carry-in, carry-out and a registered output stage. It is built as a chain of full-adder cells, with sum, carry and status flags captured on the clock edge. It is a generic arithmetic leaf used by datapath blocks that need A+B+Cin with a known one-cycle latency.

Parameters:
WIDTH, 4, operand and sum width in bits (legal range 1 to 64).

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operands valid this cycle; result captured when high
A  input  WIDTH  operand A, unsigned (two's-complement view used only for overflow)
B  input  WIDTH  operand B
Cin  input  1  carry-in
Sum  output  WIDTH  registered sum bits, (A+B+Cin) mod 2^WIDTH
Cout  output  1  registered carry-out of the MSB cell
Overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB
Zero  output  1  registered flag, high when Sum is all zeros
out_valid  output  1  high for one cycle when Sum/Cout/flags hold a newly captured result

Behaviour:
- Combinational core: WIDTH full-adder cells, instantiated via a generate loop.
  - Cell i: s[i] = A[i]^B[i]^c[i]; c[i+1] = A[i]&B[i] | c[i]&(A[i]^B[i]); c[0] = Cin.
- Required arithmetic identity: {Cout, Sum} = A + B + Cin, computed at WIDTH+1 bits with no truncation of the carry.
- Overflow = c[WIDTH] ^ c[WIDTH-1]. For WIDTH=1: Overflow = Cout ^ Cin.
- Zero = (s == 0), evaluated on the new sum before registering. Cout does not affect Zero.
- Latency: 1 cycle. Operands sampled at rising edge N with in_valid=1 appear on Sum/Cout/Overflow/Zero after edge N, and out_valid=1 during cycle N+1.
- in_valid=0 at an edge:
  - Sum, Cout, Overflow and Zero hold their previous values.
  - out_valid goes 0.
- Back-to-back valid inputs: a new result is registered every cycle and out_valid stays high continuously. No backpressure.
- Reset (asynchronous assert, release synchronous to clk):
  - Values while rst is high: Sum=0, Cout=0, Overflow=0, Zero=1, out_valid=0.
  - Reset asserted mid-stream discards the in-flight result immediately.
  - The first capture occurs at the first rising edge with rst low and in_valid high.
- Wrap-around: all-ones + 0 + Cin=1 gives Sum=0, Cout=1, Zero=1.
- X on inputs while in_valid=0 must not propagate to the outputs.
- No other internal state. Outputs are driven only from registers.

Test Plan:
1. Reset: assert rst with inputs toggling -> Sum=0000, Cout=0, Overflow=0, Zero=1, out_valid=0; outputs change immediately on rst, without waiting for clk.
2. A=0011, B=0101, Cin=0, in_valid=1 -> next cycle: Sum=1000, Cout=0, Overflow=1, Zero=0, out_valid=1.
3. A=1111, B=0001, Cin=0 -> Sum=0000, Cout=1, Overflow=0, Zero=1.
4. A=1001, B=0110, Cin=1 -> Sum=0000, Cout=1, Overflow=0, Zero=1.
5. A=0110, B=0111, Cin=1 -> Sum=1110, Cout=0, Overflow=1, Zero=0. Then drop in_valid and change A/B -> outputs hold 1110/0 and out_valid=0.
6. Exhaustive check, all 512 (A,B,Cin) combinations applied back-to-back for WIDTH=4 -> every result matches the golden A+B+Cin and the overflow/zero definitions, one cycle later, with out_valid continuously high. Also assert rst mid-run -> immediate clear, then resume correctly.
